i2s_format_ctrl: RTL and testbench



---
 rtl/i2s_format_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_i2s_format_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_format_ctrl.sv
// I2S BCK-per-frame format detector and conversion-path selector for direct_701ES.
// Locks onto 32/64/128fs streams and sequences mute around every path change.

module i2s_format_ctrl #(
  parameter int LOCK_FRAMES   = 4,
  parameter int MUTE_FRAMES   = 2,
  parameter int SETTLE_FRAMES = 8,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int CNT_W         = 9
) (
  input  logic             mck,
  input  logic             rst,
  input  logic             ext_bck,
  input  logic             ext_lrck,
  output logic [1:0]       mode_sel,
  output logic             mute,
  output logic             locked,
  output logic [CNT_W-1:0] bck_per_frame
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_MUTE   = 3'd2;
  localparam logic [2:0] ST_SWITCH = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  // Class codes share the mode_sel encoding so a confirmed class drives mode_sel directly.
  localparam logic [1:0] CLS_64      = 2'd0;
  localparam logic [1:0] CLS_32      = 2'd1;
  localparam logic [1:0] CLS_128     = 2'd2;
  localparam logic [1:0] CLS_INVALID = 2'd3;

  localparam int MATCH_W = $clog2(LOCK_FRAMES + 1);
  localparam int FRM_MAX = (MUTE_FRAMES > SETTLE_FRAMES) ? MUTE_FRAMES : SETTLE_FRAMES;
  localparam int FRM_W   = $clog2(FRM_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 2);

  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_32      = CNT_W'(32);
  localparam logic [CNT_W-1:0]   CNT_64      = CNT_W'(64);
  localparam logic [CNT_W-1:0]   CNT_128     = CNT_W'(128);
  localparam logic [MATCH_W-1:0] LOCK_MAX    = MATCH_W'(LOCK_FRAMES);
  localparam logic [FRM_W-1:0]   MUTE_LAST   = FRM_W'(MUTE_FRAMES - 1);
  localparam logic [FRM_W-1:0]   SETTLE_LAST = FRM_W'(SETTLE_FRAMES - 1);
  localparam logic [TMO_W-1:0]   TMO_HIT     = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]   TMO_DONE    = TMO_W'(TIMEOUT_CYC + 1);

  logic [2:0]         bck_sync;
  logic [2:0]         lrck_sync;
  logic               bck_rise;
  logic               frame_tick;
  logic               cls_tick;
  logic               timeout;
  logic [CNT_W-1:0]   bck_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [1:0]         frame_class;
  logic [1:0]         candidate;
  logic [MATCH_W-1:0] match_cnt;
  logic               started;
  logic               confirmed;
  logic               inv_persist;
  logic [2:0]         state;
  logic [FRM_W-1:0]   frame_cnt;

  // Two synchroniser flops per pin plus a third for edge detection.
  always_ff @(posedge mck) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
    end else begin
      bck_sync  <= {bck_sync[1:0], ext_bck};
      lrck_sync <= {lrck_sync[1:0], ext_lrck};
    end
  end

  assign bck_rise   = bck_sync[1] & ~bck_sync[2];
  assign frame_tick = lrck_sync[1] & ~lrck_sync[2];
  assign timeout    = (tmo_cnt == TMO_HIT);
  assign cls_tick   = frame_tick & started & ~timeout;

  always_ff @(posedge mck) begin
    if (rst) begin
      bck_cnt       <= '0;
      bck_per_frame <= '0;
    end else if (frame_tick) begin
      bck_per_frame <= bck_cnt;
      bck_cnt       <= CNT_W'(bck_rise);
    end else if (bck_rise && bck_cnt != CNT_MAX) begin
      bck_cnt <= bck_cnt + 1'b1;
    end
  end

  // Fires once per loss of LRCK; parking at TMO_DONE keeps it from re-firing.
  always_ff @(posedge mck) begin
    if (rst || frame_tick) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_DONE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Classify the count that bck_per_frame is about to capture, so the result is
  // available in the boundary cycle itself.
  always_comb begin
    // NOTE: default first so every path assigns frame_class and no latch is inferred.
    frame_class = CLS_INVALID;
    if (bck_cnt == CNT_32) begin
      frame_class = CLS_32;
    end else if (bck_cnt == CNT_64) begin
      frame_class = CLS_64;
    end else if (bck_cnt == CNT_128) begin
      frame_class = CLS_128;
    end
  end

  always_ff @(posedge mck) begin
    if (rst || timeout) begin
      candidate <= CLS_INVALID;
      match_cnt <= '0;
      started   <= 1'b0;
    end else if (frame_tick) begin
      started <= 1'b1;
      if (started) begin
        if (frame_class == candidate) begin
          if (match_cnt != LOCK_MAX) begin
            match_cnt <= match_cnt + 1'b1;
          end
        end else begin
          candidate <= frame_class;
          match_cnt <= MATCH_W'(1);
        end
      end
    end
  end

  assign confirmed   = (match_cnt == LOCK_MAX) && (candidate != CLS_INVALID);
  assign inv_persist = (match_cnt == LOCK_MAX) && (candidate == CLS_INVALID);

  always_ff @(posedge mck) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_sel  <= CLS_64;
      mute      <= 1'b1;
      locked    <= 1'b0;
      frame_cnt <= '0;
    end else if (timeout) begin
      state     <= ST_IDLE;
      mute      <= 1'b1;
      locked    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mute   <= 1'b1;
          locked <= 1'b0;
          if (confirmed) begin
            state <= ST_SWITCH;
          end
        end

        ST_RUN: begin
          if ((confirmed && candidate != mode_sel) || inv_persist) begin
            state     <= ST_MUTE;
            mute      <= 1'b1;
            locked    <= 1'b0;
            frame_cnt <= '0;
          end
        end

        ST_MUTE: begin
          mute   <= 1'b1;
          locked <= 1'b0;
          if (frame_tick) begin
            if (frame_cnt == MUTE_LAST) begin
              frame_cnt <= '0;
              state     <= confirmed ? ST_SWITCH : ST_IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        ST_SWITCH: begin
          mute      <= 1'b1;
          locked    <= 1'b0;
          frame_cnt <= '0;
          // Guard keeps 2'd3 off mode_sel even if a boundary slipped in since confirmation.
          if (candidate == CLS_INVALID) begin
            state <= ST_IDLE;
          end else begin
            mode_sel <= candidate;
            state    <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cls_tick) begin
            if (frame_class != mode_sel) begin
              state     <= ST_MUTE;
              frame_cnt <= '0;
            end else if (frame_cnt == SETTLE_LAST) begin
              state     <= ST_RUN;
              mute      <= 1'b0;
              locked    <= 1'b1;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          mute   <= 1'b1;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_format_ctrl.sv
// Directed bench for i2s_format_ctrl: lock, format switch, glitch immunity,
// LRCK loss timeout with relock, reset mid-settle and an unsupported format.

module tb_i2s_format_ctrl;

  localparam int TMO   = 4096;
  localparam int CNT_W = 9;

  logic             mck = 1'b0;
  logic             rst;
  logic             ext_bck;
  logic             ext_lrck;
  logic [1:0]       mode_sel;
  logic             mute;
  logic             locked;
  logic [CNT_W-1:0] bck_per_frame;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_rise_p = 0;

  logic       mon_en = 1'b0;
  logic [1:0] mon_mode = 2'd0;
  logic [1:0] prev_mode = 2'd0;
  int mute_hi = 0;
  int mute_lo = 0;
  int locked_lo = 0;
  int mode_moves = 0;
  int bad_switch = 0;
  int mode3 = 0;

  i2s_format_ctrl #(
    .LOCK_FRAMES  (4),
    .MUTE_FRAMES  (2),
    .SETTLE_FRAMES(8),
    .TIMEOUT_CYC  (TMO),
    .CNT_W        (CNT_W)
  ) dut (
    .mck          (mck),
    .rst          (rst),
    .ext_bck      (ext_bck),
    .ext_lrck     (ext_lrck),
    .mode_sel     (mode_sel),
    .mute         (mute),
    .locked       (locked),
    .bck_per_frame(bck_per_frame)
  );

  always #5 mck = ~mck;
  always @(posedge mck) cyc <= cyc + 1;

  // Observes outputs on the falling edge, away from the DUT's active edge.
  always @(negedge mck) begin
    if (mon_en) begin
      if (mute) mute_hi++;
      if (!mute) mute_lo++;
      if (!locked) locked_lo++;
      if (mode_sel != mon_mode) mode_moves++;
    end
    if (!rst && mode_sel != prev_mode && !mute) bad_switch++;
    if (mode_sel == 2'd3) mode3++;
    prev_mode = mode_sel;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input logic b, input logic l);
    @(negedge mck);
    ext_bck  = b;
    ext_lrck = l;
  endtask

  // One frame of n BCK periods (4 mck each); LRCK rises at the start of the frame.
  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, i < n / 2);
      if (i == 0) last_rise_p = cyc + 1;
      tick(1'b0, i < n / 2);
      tick(1'b1, i < n / 2);
      tick(1'b1, i < n / 2);
    end
  endtask

  task automatic mon_start(input logic [1:0] m);
    mute_hi = 0; mute_lo = 0; locked_lo = 0; mode_moves = 0;
    mon_mode = m;
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    rst = 1'b1; ext_bck = 1'b0; ext_lrck = 1'b0;
    repeat (4) @(negedge mck);
    check("rst_mode_sel", mode_sel, 0);
    check("rst_mute", mute, 1);
    check("rst_locked", locked, 0);
    check("rst_bpf", bck_per_frame, 0);
    rst = 1'b0;

    // Lock onto 64fs: boundary 1 starts counting, 2..5 confirm, 6..13 settle.
    repeat (5) frame(64);
    check("t1_bpf", bck_per_frame, 64);
    check("t1_mode", mode_sel, 0);
    check("t1_mute_early", mute, 1);
    check("t1_locked_early", locked, 0);
    repeat (7) frame(64);
    check("t1_mute_pre_run", mute, 1);
    frame(64);
    check("t1_mute_run", mute, 0);
    check("t1_locked_run", locked, 1);

    // A single 63-count frame must not disturb RUN.
    mon_start(2'd0);
    frame(63);
    frame(64);
    check("t3_bpf_glitch", bck_per_frame, 63);
    repeat (5) frame(64);
    mon_en = 1'b0;
    check("t3_mute_hi", mute_hi, 0);
    check("t3_locked_lo", locked_lo, 0);
    check("t3_mode_moves", mode_moves, 0);
    check("t3_bpf_back", bck_per_frame, 64);

    // Switch 64fs -> 32fs.
    repeat (4) frame(32);
    check("t2_mute_before", mute, 0);
    frame(32);
    check("t2_mute_rise", mute, 1);
    check("t2_locked_drop", locked, 0);
    frame(32);
    check("t2_mode_hold", mode_sel, 0);
    frame(32);
    check("t2_mode_new", mode_sel, 1);
    check("t2_mute_at_switch", mute, 1);
    repeat (7) frame(32);
    check("t2_mute_settle", mute, 1);
    frame(32);
    check("t2_mute_run", mute, 0);
    check("t2_locked_run", locked, 1);
    check("t2_bpf", bck_per_frame, 32);

    // Move to 128fs, then lose LRCK while BCK keeps running.
    repeat (15) frame(128);
    check("t4_mode_128", mode_sel, 2);
    check("t4_mute_run", mute, 0);
    target = last_rise_p + TMO + 3;
    for (int k = 0; cyc < target; k++) begin
      tick(k[1], 1'b0);
      if (cyc == target - 1) check("t4_mute_before_tmo", mute, 0);
    end
    check("t4_mute_tmo", mute, 1);
    check("t4_locked_tmo", locked, 0);
    check("t4_mode_tmo", mode_sel, 2);

    // Restart at 128fs: first boundary reports the saturated count and only starts counting.
    frame(128);
    check("t4_bpf_sat", bck_per_frame, 511);
    check("t4_mute_restart", mute, 1);
    repeat (11) frame(128);
    check("t4_mute_pre_relock", mute, 1);
    frame(128);
    check("t4_mute_relock", mute, 0);
    check("t4_locked_relock", locked, 1);
    check("t4_mode_relock", mode_sel, 2);

    // Reset in the middle of SETTLE after a switch to 32fs.
    repeat (9) frame(32);
    check("t5_mode_settle", mode_sel, 1);
    check("t5_mute_settle", mute, 1);
    @(negedge mck);
    rst = 1'b1;
    @(negedge mck);
    check("t5_rst_mode", mode_sel, 0);
    check("t5_rst_mute", mute, 1);
    check("t5_rst_locked", locked, 0);
    check("t5_rst_bpf", bck_per_frame, 0);
    rst = 1'b0;

    // Unsupported 100 BCK/frame never leaves IDLE.
    mon_start(2'd0);
    repeat (12) frame(100);
    mon_en = 1'b0;
    check("t6_mute_lo", mute_lo, 0);
    check("t6_mode_moves", mode_moves, 0);
    check("t6_locked", locked, 0);
    check("t6_bpf", bck_per_frame, 100);

    check("switch_under_mute", bad_switch, 0);
    check("mode_sel_3", mode3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
